// File: rtl/fp_div_requester_if.sv
// Bundle of host job/result streams and divider stb/ack handshakes for fp_div_requester.
// master is the requester side; slave is the host/divider environment side.
interface fp_div_requester_if #(
  parameter int unsigned TAG_W = 4
);
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic [TAG_W-1:0] in_tag;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      out_z;
  logic [TAG_W-1:0] out_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      div_a;
  logic             div_a_stb;
  logic             div_a_ack;
  logic [31:0]      div_b;
  logic             div_b_stb;
  logic             div_b_ack;
  logic [31:0]      div_z;
  logic             div_z_stb;
  logic             div_z_ack;
  logic             busy;
  logic             timeout_err;
  logic [15:0]      done_count;

  modport master (
    input  in_a, in_b, in_tag, in_valid, out_ready, div_a_ack, div_b_ack, div_z, div_z_stb,
    output in_ready, out_z, out_tag, out_valid, div_a, div_a_stb, div_b, div_b_stb, div_z_ack,
           busy, timeout_err, done_count
  );

  modport slave (
    output in_a, in_b, in_tag, in_valid, out_ready, div_a_ack, div_b_ack, div_z, div_z_stb,
    input  in_ready, out_z, out_tag, out_valid, div_a, div_a_stb, div_b, div_b_stb, div_z_ack,
           busy, timeout_err, done_count
  );
endinterface

// File: rtl/fp_div_requester.sv
// Initiator for the single-precision FP divider: buffers tagged operand pairs, issues them
// one at a time over stb/ack, and returns results in order with a job counter and timeout flag.
module fp_div_requester #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned TIMEOUT = 512
) (
  input logic                clk,
  input logic                rst,
  fp_div_requester_if.master bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] FullCnt = CW'(DEPTH);
  localparam logic [TW-1:0] TmoMax  = TW'(TIMEOUT);
  localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StSendA, StSendB, StWaitZ} state_e;

  state_e           state;
  logic [31:0]      fifo_a   [DEPTH];
  logic [31:0]      fifo_b   [DEPTH];
  logic [TAG_W-1:0] fifo_tag [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [31:0]      div_a;
  logic [31:0]      div_b;
  logic             div_a_stb;
  logic             div_b_stb;
  logic             div_z_ack;
  logic [TAG_W-1:0] held_tag;
  logic [31:0]      out_z;
  logic [TAG_W-1:0] out_tag;
  logic             out_valid;
  logic             timeout_err;
  logic [15:0]      done_count;
  logic [TW-1:0]    tmo_cnt;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             capture;

  // No pop bypass: a full FIFO refuses a push even while IDLE is popping.
  assign full    = (count == FullCnt);
  assign empty   = (count == '0);
  assign push    = bus.in_valid && !full;
  assign pop     = (state == StIdle) && !empty;
  assign capture = (state == StWaitZ) && bus.div_z_stb && div_z_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= StIdle;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      div_a       <= '0;
      div_b       <= '0;
      div_a_stb   <= 1'b0;
      div_b_stb   <= 1'b0;
      div_z_ack   <= 1'b0;
      held_tag    <= '0;
      out_z       <= '0;
      out_tag     <= '0;
      out_valid   <= 1'b0;
      timeout_err <= 1'b0;
      done_count  <= '0;
      tmo_cnt     <= '0;
    end else begin
      if (push) begin
        fifo_a[wr_ptr]   <= bus.in_a;
        fifo_b[wr_ptr]   <= bus.in_b;
        fifo_tag[wr_ptr] <= bus.in_tag;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);

      // Saturating issue-to-capture counter; the job keeps waiting after a timeout.
      if (state != StIdle) begin
        if (tmo_cnt != TmoMax) begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
        if (tmo_cnt >= TmoLast) begin
          timeout_err <= 1'b1;
        end
      end

      if (out_valid && bus.out_ready) begin
        out_valid <= 1'b0;
      end

      unique case (state)
        StIdle: begin
          if (!empty) begin
            div_a     <= fifo_a[rd_ptr];
            div_b     <= fifo_b[rd_ptr];
            held_tag  <= fifo_tag[rd_ptr];
            div_a_stb <= 1'b1;
            tmo_cnt   <= '0;
            state     <= StSendA;
          end
        end
        StSendA: begin
          if (div_a_stb && bus.div_a_ack) begin
            div_a_stb <= 1'b0;
            div_b_stb <= 1'b1;
            state     <= StSendB;
          end
        end
        StSendB: begin
          if (div_b_stb && bus.div_b_ack) begin
            div_b_stb <= 1'b0;
            state     <= StWaitZ;
          end
        end
        StWaitZ: begin
          if (capture) begin
            out_z      <= bus.div_z;
            out_tag    <= held_tag;
            out_valid  <= 1'b1;
            div_z_ack  <= 1'b0;
            done_count <= done_count + 16'd1;
            state      <= StIdle;
          end else begin
            // Only accept a result when the result register is free next cycle.
            div_z_ack <= !out_valid || bus.out_ready;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign bus.in_ready    = !full;
  assign bus.out_z       = out_z;
  assign bus.out_tag     = out_tag;
  assign bus.out_valid   = out_valid;
  assign bus.div_a       = div_a;
  assign bus.div_a_stb   = div_a_stb;
  assign bus.div_b       = div_b;
  assign bus.div_b_stb   = div_b_stb;
  assign bus.div_z_ack   = div_z_ack;
  assign bus.busy        = (state != StIdle);
  assign bus.timeout_err = timeout_err;
  assign bus.done_count  = done_count;
endmodule

// File: tb/tb_fp_div_requester.sv
// Self-checking bench for fp_div_requester: table of basic jobs plus hand-written sequences,
// a behavioural divider model, and an in-order result scoreboard.
module tb_fp_div_requester;
  logic clk;
  logic rst;

  fp_div_requester_if #(.TAG_W(4)) bus ();

  fp_div_requester #(
    .DEPTH  (4),
    .TAG_W  (4),
    .TIMEOUT(512)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic [31:0] z;
  } vec_t;

  typedef struct packed {
    logic [31:0] z;
    logic [3:0]  tag;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q[$];
  logic [31:0] cur_exp;
  bit          a_ack_en = 1'b1;
  bit          z_en = 1'b1;
  int          z_lat = 2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Stand-in for the divider datapath: known quotients for the named cases, a fixed mix otherwise.
  function automatic logic [31:0] fake_div(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h40C0_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    if (a == 32'h3F80_0000 && b == 32'h0000_0000) return 32'h7F80_0000;
    return {b[15:0], a[15:0]};
  endfunction

  // Divider model, driven just after each negedge; transfers inferred from the previous sample.
  initial begin
    logic        pb_stb, pb_ack, pz_stb, pz_ack, pending;
    logic [31:0] ma, mb;
    int          cnt;
    pb_stb = 0; pb_ack = 0; pz_stb = 0; pz_ack = 0; pending = 0; cnt = 0; ma = 0; mb = 0;
    bus.div_a_ack = 0;
    bus.div_b_ack = 0;
    bus.div_z_stb = 0;
    bus.div_z     = 0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        bus.div_z_stb = 0;
        pending = 0;
        pb_stb = 0; pb_ack = 0; pz_stb = 0; pz_ack = 0;
      end else begin
        if (pb_stb && pb_ack) begin
          ma = bus.div_a;
          mb = bus.div_b;
          pending = 1;
          cnt = z_lat;
        end
        if (pz_stb && pz_ack) begin
          bus.div_z_stb = 0;
        end else if (pending && !bus.div_z_stb) begin
          if (cnt > 0) cnt--;
          else if (z_en) begin
            bus.div_z     = fake_div(ma, mb);
            bus.div_z_stb = 1;
            pending = 0;
          end
        end
        pb_stb = bus.div_b_stb;
        pb_ack = bus.div_b_ack;
        pz_stb = bus.div_z_stb;
        pz_ack = bus.div_z_ack;
      end
      bus.div_a_ack = a_ack_en;
      bus.div_b_ack = 1'b1;
    end
  end

  // Scoreboard: push on job acceptance, pop and compare on result consumption.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        if (bus.in_valid && bus.in_ready) begin
          e.z   = cur_exp;
          e.tag = bus.in_tag;
          exp_q.push_back(e);
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            check("sb_unexpected_result", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("sb_z", bus.out_z, e.z);
            check("sb_tag", 32'(bus.out_tag), 32'(e.tag));
          end
        end
      end
    end
  end

  task automatic push_job(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_tag   = tag;
    cur_exp      = fake_div(a, b);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out_valid(input string name, input int max);
    for (int n = 0; n < max && !bus.out_valid; n++) @(negedge clk);
    check(name, 32'(bus.out_valid), 32'd1);
  endtask

  initial begin
    vec_t        vecs[4];
    logic [15:0] dc0;

    vecs[0] = '{a: 32'h40C0_0000, b: 32'h4000_0000, tag: 4'd3,  z: 32'h4040_0000};
    vecs[1] = '{a: 32'h3F80_0000, b: 32'h0000_0000, tag: 4'd5,  z: 32'h7F80_0000};
    vecs[2] = '{a: 32'h7FC0_0001, b: 32'h3F80_0000, tag: 4'd9,  z: 32'h0000_0001};
    vecs[3] = '{a: 32'h1234_5678, b: 32'h9ABC_DEF0, tag: 4'd14, z: 32'hDEF0_5678};

    rst = 1'b1;
    bus.in_valid  = 0;
    bus.in_a      = 0;
    bus.in_b      = 0;
    bus.in_tag    = 0;
    bus.out_ready = 0;
    cur_exp       = 0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_done_count", 32'(bus.done_count), 32'd0);
    check("rst_a_stb", 32'(bus.div_a_stb), 32'd0);
    check("rst_z_ack", 32'(bus.div_z_ack), 32'd0);
    check("rst_timeout", 32'(bus.timeout_err), 32'd0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);

    // Table: issue latency, A->B strobe handoff, result pass-through.
    for (int i = 0; i < 4; i++) begin
      bus.in_a     = vecs[i].a;
      bus.in_b     = vecs[i].b;
      bus.in_tag   = vecs[i].tag;
      cur_exp      = vecs[i].z;
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("tbl_no_issue_yet", 32'(bus.div_a_stb), 32'd0);
      @(negedge clk);
      check("tbl_a_stb_rise", 32'(bus.div_a_stb), 32'd1);
      check("tbl_div_a", bus.div_a, vecs[i].a);
      @(negedge clk);
      check("tbl_a_stb_fall", 32'(bus.div_a_stb), 32'd0);
      check("tbl_b_stb_rise", 32'(bus.div_b_stb), 32'd1);
      check("tbl_div_b", bus.div_b, vecs[i].b);
      wait_out_valid("tbl_result_wait", 50);
      check("tbl_out_z", bus.out_z, vecs[i].z);
      check("tbl_out_tag", 32'(bus.out_tag), 32'(vecs[i].tag));
      check("tbl_done_count", 32'(bus.done_count), 32'(i + 1));
      check("tbl_busy_idle", 32'(bus.busy), 32'd0);
      @(negedge clk);
    end

    // Backpressure: pending result blocks div_z_ack until the host drains it.
    bus.out_ready = 1'b0;
    dc0 = bus.done_count;
    push_job(32'h1111_2222, 32'h3333_4444, 4'd1);
    wait_out_valid("bp_first_wait", 50);
    push_job(32'h5555_6666, 32'h7777_8888, 4'd2);
    repeat (12) @(negedge clk);
    check("bp_z_stb_held", 32'(bus.div_z_stb), 32'd1);
    check("bp_z_ack_low", 32'(bus.div_z_ack), 32'd0);
    check("bp_first_held", 32'(bus.out_tag), 32'd1);
    check("bp_count_held", 32'(bus.done_count), 32'(dc0 + 16'd1));
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("bp_consumed", 32'(bus.out_valid), 32'd0);
    check("bp_ack_rise", 32'(bus.div_z_ack), 32'd1);
    @(negedge clk);
    check("bp_second_valid", 32'(bus.out_valid), 32'd1);
    check("bp_second_tag", 32'(bus.out_tag), 32'd2);
    check("bp_ack_fall", 32'(bus.div_z_ack), 32'd0);
    bus.out_ready = 1'b1;
    @(negedge clk);

    // FIFO full: divider refuses A, so 1 issued + 4 buffered, 6th refused.
    a_ack_en = 1'b0;
    dc0 = bus.done_count;
    for (int k = 0; k < 5; k++) begin
      bus.in_a     = 32'h1000_0000 + 32'(k);
      bus.in_b     = 32'h2000_0100 + 32'(k);
      bus.in_tag   = 4'(k);
      cur_exp      = fake_div(bus.in_a, bus.in_b);
      bus.in_valid = 1'b1;
      check("full_accept", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
    end
    bus.in_a   = 32'h1000_0005;
    bus.in_b   = 32'h2000_0105;
    bus.in_tag = 4'd5;
    cur_exp    = fake_div(bus.in_a, bus.in_b);
    check("full_sixth_refused", 32'(bus.in_ready), 32'd0);
    repeat (3) @(negedge clk);
    check("full_still_refused", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;
    a_ack_en = 1'b1;
    for (int n = 0; n < 300 && bus.done_count != dc0 + 16'd5; n++) @(negedge clk);
    check("full_drain_count", 32'(bus.done_count), 32'(dc0 + 16'd5));
    repeat (2) @(negedge clk);
    check("full_sb_empty", 32'(exp_q.size()), 32'd0);

    // Timeout: no result for 512 cycles after issue.
    z_en = 1'b0;
    push_job(32'h4120_0000, 32'h4080_0000, 4'd7);
    for (int n = 0; n < 20 && !bus.div_a_stb; n++) @(negedge clk);
    check("tmo_issued", 32'(bus.div_a_stb), 32'd1);
    repeat (511) @(negedge clk);
    check("tmo_not_yet", 32'(bus.timeout_err), 32'd0);
    @(negedge clk);
    check("tmo_set", 32'(bus.timeout_err), 32'd1);
    z_en = 1'b1;
    wait_out_valid("tmo_late_wait", 50);
    check("tmo_late_tag", 32'(bus.out_tag), 32'd7);
    check("tmo_sticky", 32'(bus.timeout_err), 32'd1);
    @(negedge clk);

    // Reset mid-operation with jobs buffered.
    z_en = 1'b0;
    push_job(32'h4200_0000, 32'h4100_0000, 4'd10);
    for (int n = 0; n < 20 && !bus.div_z_ack; n++) @(negedge clk);
    check("rstmid_in_wait_z", 32'(bus.div_z_ack), 32'd1);
    push_job(32'h4300_0000, 32'h4100_0000, 4'd11);
    push_job(32'h4400_0000, 32'h4100_0000, 4'd12);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("rstmid_a_stb", 32'(bus.div_a_stb), 32'd0);
    check("rstmid_b_stb", 32'(bus.div_b_stb), 32'd0);
    check("rstmid_z_ack", 32'(bus.div_z_ack), 32'd0);
    check("rstmid_in_ready", 32'(bus.in_ready), 32'd1);
    check("rstmid_out_valid", 32'(bus.out_valid), 32'd0);
    check("rstmid_done_count", 32'(bus.done_count), 32'd0);
    check("rstmid_timeout", 32'(bus.timeout_err), 32'd0);
    rst  = 1'b0;
    z_en = 1'b1;
    @(negedge clk);
    check("rstmid_idle", 32'(bus.busy), 32'd0);
    push_job(vecs[0].a, vecs[0].b, vecs[0].tag);
    wait_out_valid("rstmid_new_wait", 50);
    check("rstmid_new_z", bus.out_z, vecs[0].z);
    check("rstmid_new_tag", 32'(bus.out_tag), 32'(vecs[0].tag));
    check("rstmid_new_count", 32'(bus.done_count), 32'd1);
    repeat (2) @(negedge clk);
    check("final_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp_div_requester.md
Name: fp_div_requester

Overview:
- Initiator-side companion to the single-precision FP divider.
- Takes tagged operand-pair jobs from a host valid/ready stream and buffers them in a small FIFO.
- Drives the divider's stb/ack operand handshakes (a, then b), then collects the divider's stb/ack result and returns it with its tag on a valid/ready output.
- One division is outstanding at a time; results come back in order. Also keeps a completed-job counter and a sticky timeout flag.

Parameters:
- DEPTH, 4: operand FIFO entries; must be a power of two, at least 2.
- TAG_W, 4: width of the job tag carried alongside each operand pair.
- TIMEOUT, 512: cycles from operand issue to result capture before timeout_err sets.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_a  in  32  dividend, IEEE-754 single.
- in_b  in  32  divisor, IEEE-754 single.
- in_tag  in  TAG_W  job tag.
- in_valid  in  1  host job valid.
- in_ready  out  1  FIFO can accept a job; equals not-full.
- out_z  out  32  quotient.
- out_tag  out  TAG_W  tag of the returned job.
- out_valid  out  1  result register holds a result.
- out_ready  in  1  host consumes the result.
- div_a  out  32  operand A to divider.
- div_a_stb  out  1  A strobe.
- div_a_ack  in  1  divider ready for A.
- div_b  out  32  operand B to divider.
- div_b_stb  out  1  B strobe.
- div_b_ack  in  1  divider ready for B.
- div_z  in  32  divider result.
- div_z_stb  in  1  divider result strobe.
- div_z_ack  out  1  requester accepts the result.
- busy  out  1  high when the state machine is not IDLE.
- timeout_err  out  1  sticky timeout flag.
- done_count  out  16  completed-job counter; wraps 0xFFFF to 0.

Behaviour:
- Reset (synchronous, active-high, takes precedence over everything):
  - Clears to 0: state (IDLE), FIFO pointers/count, all stb/ack outputs, out_valid, timeout_err, done_count, timeout counter.
  - div_a, div_b, out_z, out_tag reset to 0.
  - A reset mid-operation abandons the job in flight and all FIFO contents. The divider must be reset together with this block.
- Transfer rule on every stb/ack pair: a transfer occurs at a posedge where both stb and ack are sampled high. The requester never drops a stb before its transfer and keeps div_a/div_b stable while the stb is high.
- FIFO:
  - Push when in_valid && in_ready.
  - in_ready = !full, computed without a pop bypass: a full FIFO refuses a push even on a pop cycle.
  - A push into an empty FIFO is not visible to IDLE until the following cycle.
  - Pointers wrap modulo DEPTH.
- State machine, all outputs registered:
  - IDLE: if the FIFO is non-empty, pop the head, load div_a, div_b and the held tag, set div_a_stb<=1, clear the timeout counter, go to SEND_A. busy=0 only in IDLE.
  - SEND_A: on div_a_stb && div_a_ack, set div_a_stb<=0 and div_b_stb<=1, go to SEND_B.
  - SEND_B: on div_b_stb && div_b_ack, set div_b_stb<=0, go to WAIT_Z.
  - WAIT_Z, acknowledge: div_z_ack<=1 iff the result register will be empty next cycle (out_valid==0, or out_valid && out_ready).
  - WAIT_Z, capture: on div_z_stb && div_z_ack, set out_z<=div_z, out_tag<=held tag, out_valid<=1, div_z_ack<=0, done_count<=done_count+1, go to IDLE.
  - The divider drops div_z_stb the cycle after capture; ack low then is harmless.
- Result register:
  - out_valid clears on out_valid && out_ready unless a capture occurs in the same cycle; a capture wins and sets out_valid.
- Timeout:
  - The counter increments each cycle in SEND_A, SEND_B and WAIT_Z and saturates.
  - When it reaches TIMEOUT, timeout_err<=1. It stays set until reset.
  - The job is not aborted; the state machine keeps waiting.
- Latency:
  - Job pushed at posedge T into an empty FIFO with the block in IDLE: pop at T+1, div_a_stb high after T+1.
  - Minimum overhead added to divider latency: 1 cycle issue + 1 cycle capture.
- Special values pass through untouched; the requester never inspects operand or result bits.

Test Plan:
- Basic job: push a=0x40C00000 (6.0), b=0x40000000 (2.0), tag=3; the divider model returns 0x40400000 → out_z=0x40400000, out_tag=3, done_count=1, busy returns to 0.
- Special value: a=0x3F800000 (1.0), b=0x00000000 → out_z=0x7F800000 passes through unchanged. Check that div_a_stb fell exactly one cycle after the A transfer and div_b_stb rose in that same cycle.
- Backpressure: hold out_ready=0 with one result already pending; the divider model raises div_z_stb → div_z_ack stays 0 and the first result is held. Raise out_ready for 1 cycle → first result consumed, ack asserted, second result captured, tags in order.
- FIFO full (DEPTH=4): hold div_a_ack=0 and push jobs back to back → 5 jobs accepted (1 issued + 4 buffered), in_ready=0 on the 6th. Release ack → all 5 results return in tag order.
- Timeout (TIMEOUT=512): the divider model never asserts div_z_stb → timeout_err rises after exactly 512 cycles in SEND_A..WAIT_Z. A late result is still captured; timeout_err remains 1.
- Reset mid-operation: assert rst in WAIT_Z with 2 jobs buffered → next cycle all stb/ack=0, in_ready=1, out_valid=0, done_count=0. A new job completes normally.
